channel_sampler_pack: RTL and testbench
=======================================

Name: channel_sampler_pack

Overview:
Parametrised multi-channel front-end sampler for the logic-analyzer capture path. It synchronises each channel's low/high comparator outputs into the clk domain and takes a sample on each smpl_en strobe. Successive samples are packed into one word per channel and handed to the capture RAM writer over a valid/ready handshake, with overflow detection. All logic runs on a single clock; the sample rate comes from smpl_en, not a second clock.

Parameters:
NUM_CH, 1, number of channels; each channel has one low and one high comparator input.
SMPL_PER_WORD, 4, samples packed per output word; legal range 2..16.
SYNC_STAGES, 2, synchroniser depth per comparator input; legal range 2..4.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
smpl_en  input  1  one-cycle sample strobe from the decimator.
clr  input  1  synchronous clear of the packing state, handshake and flags.
ch_low  input  NUM_CH  raw low-threshold comparator outputs (asynchronous).
ch_high  input  NUM_CH  raw high-threshold comparator outputs (asynchronous).
ch_low_sync  output  NUM_CH  synchronised ch_low (last sync stage).
ch_high_sync  output  NUM_CH  synchronised ch_high (last sync stage).
smpl  output  NUM_CH*2*SMPL_PER_WORD  packed words; channel c occupies slice [c*W +: W], where W = 2*SMPL_PER_WORD.
smpl_vld  output  1  smpl holds a complete, unconsumed word.
smpl_rdy  input  1  consumer accepts the word when smpl_vld && smpl_rdy.
ovfl  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (rst_n low, async): all sync flops, pack register, pack counter, smpl, smpl_vld and ovfl go to 0.
- Sync: each ch_low/ch_high bit passes through a SYNC_STAGES flop chain. An input change appears on *_sync exactly SYNC_STAGES clk edges later. clr does not affect the sync chains.
- Sampling: on a clk edge with smpl_en=1 and clr=0:
  - The current {ch_high_sync[c], ch_low_sync[c]} pair is written into pack slot k = pack_cnt (k = 0..SMPL_PER_WORD-1).
  - Slot k occupies bits [2k+1:2k] of the channel word: bit 2k = low, bit 2k+1 = high.
  - Slot 0 is the oldest sample; the highest slot is the newest.
  - pack_cnt is $clog2(SMPL_PER_WORD) bits wide. It increments and wraps to 0 after slot SMPL_PER_WORD-1.
- Word completion: the edge that writes the last slot also completes the word.
  - If the output slot is free, or is being accepted this same edge (smpl_vld && smpl_rdy), the full word for all channels (including the final pair) loads into smpl and smpl_vld=1 from the next cycle. Latency from last-slot smpl_en edge to smpl_vld is one edge.
  - Otherwise (smpl_vld=1 and smpl_rdy=0): the new word is discarded, smpl keeps the old word, ovfl is set, and pack_cnt still wraps to 0.
- Handshake: smpl_vld stays high and smpl stays stable until accepted. Acceptance without a new completion clears smpl_vld on the next edge; smpl is not required to change. smpl_rdy is ignored while smpl_vld=0.
- clr (synchronous, highest priority after reset):
  - Zeroes pack_cnt, the partial pack register, smpl_vld and ovfl.
  - A smpl_en in the same cycle is dropped.
  - A word completing in the same cycle is dropped, and ovfl stays 0.
- smpl_en held high for consecutive cycles samples every cycle; no minimum spacing.
- ovfl clears only on clr or reset.

Optional Feature:
Macro TRIG_EDGE_EN.
- Defined: adds outputs trig_pos [NUM_CH] and trig_neg [NUM_CH], both reset 0 and registered.
  - trig_pos[c] pulses high for one cycle when ch_high_sync[c] goes 0->1.
  - trig_neg[c] pulses high for one cycle when ch_low_sync[c] goes 1->0.
  - Edge detection runs every clk cycle regardless of smpl_en. Pulses appear one edge after the *_sync transition. clr does not suppress them.
- Not defined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- NUM_CH=1, SMPL_PER_WORD=4, SYNC_STAGES=2. Drive {high,low} = 00,01,11,10 (already synced), one smpl_en each, smpl_rdy=1 -> smpl=8'b10_11_01_00, smpl_vld high for exactly one cycle, one edge after the 4th strobe.
- Toggle ch_high 0->1 at an arbitrary phase -> ch_high_sync rises on exactly the 2nd subsequent clk edge. Repeat with SYNC_STAGES=3 -> 3rd edge.
- smpl_rdy=0, complete two words (second = 8'hFF) -> smpl holds the first word, ovfl=1. Then assert smpl_rdy -> first word accepted, smpl_vld=0 next cycle. Pulse clr -> ovfl=0.
- Assert smpl_rdy on the same edge the next word completes -> new word loads, smpl_vld stays 1, ovfl stays 0.
- After 2 samples, pulse clr together with smpl_en, then 4 samples of 11 -> smpl=8'hFF (no stale slots). Assert rst_n=0 mid-word -> all outputs 0 asynchronously.
- NUM_CH=3, SMPL_PER_WORD=2 -> each channel's 4-bit word in its own slice, no cross-channel mixing. With TRIG_EDGE_EN, ch_low 1->0 on ch 1 -> trig_neg=3'b010 for one cycle.

Source files
------------

// File: rtl/channel_sampler_pack.sv
// rtl/channel_sampler_pack.sv - comparator synchroniser, sample packer and valid/ready word output
// Optional macro TRIG_EDGE_EN adds registered trig_pos/trig_neg edge pulses.
module channel_sampler_pack #(
    parameter int NUM_CH        = 1,
    parameter int SMPL_PER_WORD = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              smpl_en,
    input  logic                              clr,
    input  logic [NUM_CH-1:0]                 ch_low,
    input  logic [NUM_CH-1:0]                 ch_high,
    output logic [NUM_CH-1:0]                 ch_low_sync,
    output logic [NUM_CH-1:0]                 ch_high_sync,
    output logic [NUM_CH*2*SMPL_PER_WORD-1:0] smpl,
    output logic                              smpl_vld,
    input  logic                              smpl_rdy,
    output logic                              ovfl
`ifdef TRIG_EDGE_EN
    ,
    output logic [NUM_CH-1:0]                 trig_pos,
    output logic [NUM_CH-1:0]                 trig_neg
`endif
);

    localparam int W  = 2 * SMPL_PER_WORD;
    localparam int PW = NUM_CH * W;
    localparam int CW = $clog2(SMPL_PER_WORD);

    logic [NUM_CH-1:0] r_low_sync  [SYNC_STAGES];
    logic [NUM_CH-1:0] r_high_sync [SYNC_STAGES];
    logic [PW-1:0]     r_pack;
    logic [PW-1:0]     r_smpl;
    logic [CW-1:0]     r_cnt;
    logic              r_vld;
    logic              r_ovfl;

    logic [PW-1:0]     w_pack_nxt;
    logic              w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_low_sync[s]  <= '0;
                r_high_sync[s] <= '0;
            end
        end else begin
            r_low_sync[0]  <= ch_low;
            r_high_sync[0] <= ch_high;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_low_sync[s]  <= r_low_sync[s-1];
                r_high_sync[s] <= r_high_sync[s-1];
            end
        end
    end

    assign ch_low_sync  = r_low_sync[SYNC_STAGES-1];
    assign ch_high_sync = r_high_sync[SYNC_STAGES-1];

    // The completed word includes the pair written on this same edge.
    always_comb begin
        w_pack_nxt = r_pack;
        for (int c = 0; c < NUM_CH; c++) begin
            w_pack_nxt[c*W + 2*int'(r_cnt) +: 2] = {ch_high_sync[c], ch_low_sync[c]};
        end
    end

    assign w_last = smpl_en && (r_cnt == CW'(SMPL_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack <= '0;
            r_smpl <= '0;
            r_cnt  <= '0;
            r_vld  <= 1'b0;
            r_ovfl <= 1'b0;
        end else if (clr) begin
            r_pack <= '0;
            r_cnt  <= '0;
            r_vld  <= 1'b0;
            r_ovfl <= 1'b0;
        end else begin
            if (smpl_en) begin
                r_pack <= w_pack_nxt;
                r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
            end
            if (w_last) begin
                if (!r_vld || smpl_rdy) begin
                    r_smpl <= w_pack_nxt;
                    r_vld  <= 1'b1;
                end else begin
                    r_ovfl <= 1'b1;
                end
            end else if (r_vld && smpl_rdy) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign smpl     = r_smpl;
    assign smpl_vld = r_vld;
    assign ovfl     = r_ovfl;

`ifdef TRIG_EDGE_EN
    logic [NUM_CH-1:0] r_low_d;
    logic [NUM_CH-1:0] r_high_d;
    logic [NUM_CH-1:0] r_trig_pos;
    logic [NUM_CH-1:0] r_trig_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low_d    <= '0;
            r_high_d   <= '0;
            r_trig_pos <= '0;
            r_trig_neg <= '0;
        end else begin
            r_low_d    <= ch_low_sync;
            r_high_d   <= ch_high_sync;
            r_trig_pos <= ch_high_sync & ~r_high_d;
            r_trig_neg <= ~ch_low_sync & r_low_d;
        end
    end

    assign trig_pos = r_trig_pos;
    assign trig_neg = r_trig_neg;
`endif

endmodule

// File: tb/tb_channel_sampler_pack.sv
// tb/tb_channel_sampler_pack.sv - randomized bench for channel_sampler_pack against a queue-based model
module tb_channel_sampler_pack;

    localparam int NUM_CH = 2;
    localparam int SPW    = 4;
    localparam int S      = 2;
    localparam int W      = 2 * SPW;
    localparam int PW     = NUM_CH * W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              smpl_en = 1'b0;
    logic              clr = 1'b0;
    logic [NUM_CH-1:0] ch_low = '0;
    logic [NUM_CH-1:0] ch_high = '0;
    logic [NUM_CH-1:0] ch_low_sync;
    logic [NUM_CH-1:0] ch_high_sync;
    logic [PW-1:0]     smpl;
    logic              smpl_vld;
    logic              smpl_rdy = 1'b0;
    logic              ovfl;
`ifdef TRIG_EDGE_EN
    logic [NUM_CH-1:0] trig_pos;
    logic [NUM_CH-1:0] trig_neg;
`endif

    channel_sampler_pack #(
        .NUM_CH(NUM_CH), .SMPL_PER_WORD(SPW), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .rst_n(rst_n), .smpl_en(smpl_en), .clr(clr),
        .ch_low(ch_low), .ch_high(ch_high),
        .ch_low_sync(ch_low_sync), .ch_high_sync(ch_high_sync),
        .smpl(smpl), .smpl_vld(smpl_vld), .smpl_rdy(smpl_rdy), .ovfl(ovfl)
`ifdef TRIG_EDGE_EN
        , .trig_pos(trig_pos), .trig_neg(trig_neg)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Input history, newest first: sync output after an edge is the input seen S-1 edges earlier.
    logic [NUM_CH-1:0] q_low[$];
    logic [NUM_CH-1:0] q_high[$];
    logic [NUM_CH-1:0] cur_low[$];
    logic [NUM_CH-1:0] cur_high[$];
    logic [PW-1:0]     m_smpl;
    logic              m_vld;
    logic              m_ovfl;

    function automatic logic [NUM_CH-1:0] hist(input bit hi, input int i);
        if (hi) return (q_high.size() > i) ? q_high[i] : '0;
        return (q_low.size() > i) ? q_low[i] : '0;
    endfunction

    task automatic model_reset();
        q_low.delete(); q_high.delete(); cur_low.delete(); cur_high.delete();
        m_smpl = '0; m_vld = 1'b0; m_ovfl = 1'b0;
    endtask

    task automatic model_edge();
        logic [NUM_CH-1:0] s_low, s_high;
        logic [PW-1:0]     word;
        bit                done;
        s_low  = hist(0, S-1);
        s_high = hist(1, S-1);
        q_low.push_front(ch_low);
        q_high.push_front(ch_high);
        while (q_low.size() > S + 2) begin
            void'(q_low.pop_back());
            void'(q_high.pop_back());
        end
        if (clr) begin
            cur_low.delete(); cur_high.delete();
            m_vld = 1'b0; m_ovfl = 1'b0;
        end else begin
            done = 1'b0;
            word = '0;
            if (smpl_en) begin
                cur_low.push_back(s_low);
                cur_high.push_back(s_high);
                if (cur_low.size() == SPW) begin
                    for (int c = 0; c < NUM_CH; c++)
                        for (int k = 0; k < SPW; k++) begin
                            word[c*W + 2*k]     = cur_low[k][c];
                            word[c*W + 2*k + 1] = cur_high[k][c];
                        end
                    cur_low.delete(); cur_high.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!m_vld || smpl_rdy) begin m_smpl = word; m_vld = 1'b1; end
                else m_ovfl = 1'b1;
            end else if (m_vld && smpl_rdy) begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("smpl", 64'(smpl), 64'(m_smpl));
        check("smpl_vld", 64'(smpl_vld), 64'(m_vld));
        check("ovfl", 64'(ovfl), 64'(m_ovfl));
        check("ch_low_sync", 64'(ch_low_sync), 64'(hist(0, S-1)));
        check("ch_high_sync", 64'(ch_high_sync), 64'(hist(1, S-1)));
`ifdef TRIG_EDGE_EN
        check("trig_pos", 64'(trig_pos), 64'(hist(1, S) & ~hist(1, S+1)));
        check("trig_neg", 64'(trig_neg), 64'(~hist(0, S) & hist(0, S+1)));
`endif
    endtask

    initial begin
        int rdy_pct, en_pct;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        rdy_pct = 60; en_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            compare_all();
            if (i % 64 == 0) begin
                case ($urandom_range(2, 0))
                    0: rdy_pct = 0;
                    1: rdy_pct = 30;
                    default: rdy_pct = 95;
                endcase
                en_pct = (i % 128 == 0) ? 100 : 50;
            end
            if (i == 2500) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                smpl_en = 1'b0; clr = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                continue;
            end
            smpl_en  = ($urandom_range(99, 0) < en_pct);
            smpl_rdy = ($urandom_range(99, 0) < rdy_pct);
            clr      = ($urandom_range(99, 0) < 3);
            ch_low   = NUM_CH'($urandom);
            ch_high  = NUM_CH'($urandom);
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        compare_all();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
